// File: rtl/rr_dispatch.sv
// Round-robin 1-to-N dispatcher: one valid/ready stream spread over N ports,
// each port backed by a one-entry output register.
module rr_dispatch #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   init_pri,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [W-1:0]   s_data,
  output logic [N-1:0]   m_valid,
  input  logic [N-1:0]   m_ready,
  output logic [N*W-1:0] m_data
);

  logic [N-1:0]        full_q, full_d;
  logic [N-1:0]        ptr_q, ptr_d;
  logic [N-1:0][W-1:0] data_q, data_d;
  logic [N-1:0]        avail, sel;
  logic [2*N-1:0]      avail2, grant2;
  logic                acc, init_ok;

  // A slot draining this cycle counts as free, so it can be reloaded at once.
  assign avail   = ~full_q | m_ready;
  assign s_ready = |avail;
  assign acc     = s_valid & s_ready;

  // Circular search from the pointer: the borrow of the double-width subtract
  // stops at the first available bit at or above the pointer, wrapping via the upper copy.
  assign avail2 = {avail, avail};
  assign grant2 = avail2 & ~(avail2 - {{N{1'b0}}, ptr_q});
  assign sel    = grant2[N-1:0] | grant2[2*N-1:N];

  assign init_ok = (init_pri != '0) && ((init_pri & (init_pri - 1'b1)) == '0);

  always_comb begin
    full_d = full_q & ~m_ready;
    data_d = data_q;
    ptr_d  = ptr_q;
    if (acc) begin
      full_d = full_d | sel;
      ptr_d  = {sel[N-2:0], sel[N-1]};
      for (int i = 0; i < N; i++) begin
        if (sel[i]) data_d[i] = s_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= '0;
      data_q <= '0;
      ptr_q  <= init_ok ? init_pri : {{(N-1){1'b0}}, 1'b1};
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      ptr_q  <= ptr_d;
    end
  end

  assign m_valid = full_q;
  assign m_data  = data_q;

endmodule

// File: tb/tb_rr_dispatch.sv
// Self-checking bench for rr_dispatch: vector tables with hand-derived target
// ports, a slot shadow model, and a scoreboard of accepted beats.
module tb_rr_dispatch;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   init_pri = 4'b0001;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [W-1:0]   s_data = '0;
  logic [N-1:0]   m_valid;
  logic [N-1:0]   m_ready = '0;
  logic [N*W-1:0] m_data;

  rr_dispatch #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .init_pri(init_pri),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [31:0] d;
    logic [3:0]  mr;
    logic        rdy;
    int          port;
  } vec_t;

  typedef struct {
    int          port;
    logic [31:0] d;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  logic        mf[N];
  logic [31:0] md[N];
  int          errors = 0;
  int          checks = 0;

  function automatic void add(logic sv, logic [31:0] d, logic [3:0] mr, logic rdy, int port);
    vec_t v;
    v.sv = sv; v.d = d; v.mr = mr; v.rdy = rdy; v.port = port;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic compare_outputs();
    logic [3:0]   emv;
    logic [127:0] emd;
    for (int i = 0; i < N; i++) begin
      emv[i] = mf[i];
      emd[i*W +: W] = md[i];
    end
    check("m_valid", m_valid, emv);
    check("m_data", m_data, emd);
  endtask

  task automatic apply(vec_t v);
    exp_t e;
    @(negedge clk);
    rst_n = 1'b1;
    s_valid = v.sv;
    s_data = v.d;
    m_ready = v.mr;
    #1;
    check("s_ready", s_ready, v.rdy);
    for (int i = 0; i < N; i++) if (v.mr[i]) mf[i] = 1'b0;
    if (v.port >= 0) begin
      mf[v.port] = 1'b1;
      md[v.port] = v.d;
      e.port = v.port;
      e.d = v.d;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_valid", m_valid[e.port], 1'b1);
      check("sb_data", m_data[e.port*W +: W], e.d);
    end
    compare_outputs();
  endtask

  task automatic run_vecs();
    foreach (vecs[k]) apply(vecs[k]);
    vecs.delete();
  endtask

  // Reset for one edge while offering a beat, which must be ignored.
  task automatic do_reset(logic [3:0] ip, logic [3:0] mr, logic exp_rdy);
    @(negedge clk);
    rst_n = 1'b0;
    init_pri = ip;
    s_valid = 1'b1;
    s_data = 32'hFFFF_FFFF;
    m_ready = mr;
    #1;
    check("rst_s_ready", s_ready, exp_rdy);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      mf[i] = 1'b0;
      md[i] = '0;
    end
    sb.delete();
    compare_outputs();
  endtask

  initial begin
    // 1: plain rotation from port 0, one beat per cycle.
    do_reset(4'b0001, 4'b0000, 1'b1);
    for (int i = 0; i < 8; i++) add(1'b1, i, 4'b1111, 1'b1, i % 4);
    add(1'b0, 32'h0, 4'b1111, 1'b1, -1);
    run_vecs();

    // 2: start at port 2 with port 2 stalled; E must skip port 2.
    do_reset(4'b0100, 4'b1111, 1'b1);
    add(1'b1, 32'hA, 4'b1011, 1'b1, 2);
    add(1'b1, 32'hB, 4'b1011, 1'b1, 3);
    add(1'b1, 32'hC, 4'b1011, 1'b1, 0);
    add(1'b1, 32'hD, 4'b1011, 1'b1, 1);
    add(1'b1, 32'hE, 4'b1011, 1'b1, 3);
    add(1'b0, 32'h0, 4'b1111, 1'b1, -1);
    run_vecs();

    // 3: all stalled, fifth beat waits, then reloads port 1 as it drains.
    do_reset(4'b0001, 4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) add(1'b1, 32'h10 + i, 4'b0000, 1'b1, i);
    add(1'b1, 32'h14, 4'b0000, 1'b0, -1);
    add(1'b1, 32'h14, 4'b0000, 1'b0, -1);
    add(1'b1, 32'h14, 4'b0010, 1'b1, 1);
    add(1'b0, 32'h0, 4'b0000, 1'b0, -1);
    add(1'b0, 32'h0, 4'b1111, 1'b1, -1);
    run_vecs();

    // 4: port 0 held with 0xDEAD for 10 cycles while others stream.
    do_reset(4'b0001, 4'b0000, 1'b1);
    add(1'b1, 32'hDEAD, 4'b1110, 1'b1, 0);
    for (int i = 0; i < 10; i++) add(1'b1, 32'h100 + i, 4'b1110, 1'b1, 1 + (i % 3));
    add(1'b0, 32'h0, 4'b1111, 1'b1, -1);
    run_vecs();

    // 5: reset with three slots full, pointer reloads to port 3.
    do_reset(4'b0001, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) add(1'b1, 32'h20 + i, 4'b0000, 1'b1, i);
    run_vecs();
    do_reset(4'b1000, 4'b0000, 1'b1);
    add(1'b1, 32'h30, 4'b1111, 1'b1, 3);
    add(1'b1, 32'h31, 4'b1111, 1'b1, 0);
    add(1'b0, 32'h0, 4'b1111, 1'b1, -1);
    run_vecs();

    // 6: invalid init_pri falls back to port 0.
    do_reset(4'b0110, 4'b1111, 1'b1);
    for (int i = 0; i < 4; i++) add(1'b1, 32'h40 + i, 4'b1111, 1'b1, i);
    add(1'b0, 32'h0, 4'b1111, 1'b1, -1);
    run_vecs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
